sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 The module SHALL have parameters, one per line:
- ADDR_W, 12, address width.
- DATA_W, 8, data width.
- SETUP_CYC, 1, cycles of address/data setup before the write strobe; legal range 1..15.
- PULSE_CYC, 2, cycles the write strobe is held low; legal range 1..15.
- READ_CYC, 2, cycles from chip-select low to read sample; legal range 1..15.
REQ-002 The module SHALL have ports, one per line:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rd_valid  out  1  one-cycle strobe; rd_data valid.
- rd_data  out  DATA_W  read result.
- sram_csb  out  1  active-low chip select to SRAM.
- sram_wrb  out  1  active-low write strobe to SRAM.
- sram_abus  out  ADDR_W  SRAM address bus.
- sram_dbus  inout  DATA_W  SRAM bidirectional data bus.
REQ-003 One clock and one reset SHALL be used: reset_n is asynchronous and active-low; no other clock or reset exists.

Function
REQ-004 sram_csb, sram_wrb, sram_abus, the dbus output-enable and the dbus output value SHALL be driven directly from flops, with no combinational path from inputs, so the strobes are glitch-free.
REQ-005 req_ready SHALL equal (state == IDLE); a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-006 The FSM states SHALL be IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS and R_TURN; a 4-bit down-counter times each state.
REQ-007 On write acceptance, address and data SHALL be latched, and the FSM SHALL enter W_SETUP for SETUP_CYC cycles with csb=0, wrb=1, abus=addr and dbus driven with the data.
REQ-008 The FSM SHALL then enter W_PULSE for PULSE_CYC cycles with wrb=0, csb=0, and address and data unchanged.
REQ-009 The FSM SHALL then enter W_HOLD for 1 cycle with wrb=1, csb=0, and address and data still driven, so that data and address are stable across the wrb rising edge.
REQ-010 At the end of W_HOLD, the FSM SHALL return to IDLE with csb=1 and dbus released on the same edge; a write occupies SETUP_CYC+PULSE_CYC+1 cycles.
REQ-011 On read acceptance, the address SHALL be latched, dbus SHALL be released, and the FSM SHALL enter R_ACCESS for READ_CYC cycles with csb=0 and wrb=1.
REQ-012 On the last R_ACCESS edge, sram_dbus SHALL be sampled into rd_data.
REQ-013 On that same edge, rd_valid SHALL be set for exactly 1 cycle, csb SHALL be set to 1, and the FSM SHALL enter R_TURN.
REQ-014 R_TURN SHALL last 1 cycle (bus turnaround: the SRAM stops driving), with dbus not driven and req_ready=0, then return to IDLE; read latency is READ_CYC+1 cycles from acceptance to rd_valid.
REQ-015 In IDLE, outputs SHALL be csb=1, wrb=1, dbus released, and abus holding its last value.
REQ-016 The controller SHALL never drive sram_dbus while csb=0 with wrb=1 in a read state, nor in the cycle following a read (R_TURN); a write immediately after a read SHALL begin no earlier than one cycle after R_TURN.
REQ-017 Back-to-back requests SHALL be supported: a request held valid through IDLE is accepted on the first IDLE edge, with no idle gap beyond the one IDLE cycle.
REQ-018 req_addr, req_we and req_wdata SHALL be ignored when not accepted, and changes to them during a transaction SHALL have no effect.
REQ-019 rd_data SHALL hold its value until the next read sample.

Reset
REQ-020 While reset_n=0, and immediately on its assertion (asynchronously), outputs SHALL be: state=IDLE, csb=1, wrb=1, dbus released, abus=0, rd_valid=0, rd_data=0, counter=0.
REQ-021 Reset asserted mid-write SHALL abort the write with no further strobes; wrb and csb rise asynchronously, and the resulting partial write to the SRAM is permitted.
REQ-022 req_ready SHALL be 1 from the first cycle after reset_n deasserts.

Verification
REQ-023 Single write, defaults: req addr=0x123, data=0xA5 -> csb low for 4 cycles, wrb low on cycles 2-3, SRAM model cell 0x123 = 0xA5, req_ready high again on cycle 5.
REQ-024 Single read after REQ-023: read 0x123 -> rd_valid pulses on cycle 3 after acceptance with rd_data=0xA5, followed by one R_TURN cycle with req_ready=0.
REQ-025 Read followed by write: read 0x010, then write 0x010=0x3C held valid -> no cycle in which both the controller and the SRAM drive dbus (no X on dbus); a subsequent read returns 0x3C.
REQ-026 Streaming: 16 writes to addresses 0x000-0x00F with data = address XOR 0x5A, then 16 reads -> all reads match; every wrb rising edge occurs at least 10 ns after an abus change (the SRAM model's setup check stays silent).
REQ-027 Reset mid-operation: assert reset_n=0 during W_PULSE -> csb and wrb go to 1 asynchronously with no clock edge, dbus goes to Z, and after release req_ready=1 with a clean next transaction.
REQ-028 Parameter sweep: SETUP_CYC=3, PULSE_CYC=1, READ_CYC=4 -> write occupies 5 cycles and read rd_valid arrives 5 cycles after acceptance.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port asynchronous SRAM controller.
// Accepts one read or write request at a time through a valid/ready handshake
// and sequences chip select, write strobe, address and data bus timing.
// Every SRAM-facing signal comes straight from a flop, so the strobes are
// glitch-free.
`timescale 1ns/1ps

module sram_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int READ_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              sram_csb,
  output logic              sram_wrb,
  output logic [ADDR_W-1:0] sram_abus,
  inout  wire  [DATA_W-1:0] sram_dbus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] W_SETUP  = 3'd1;
  localparam logic [2:0] W_PULSE  = 3'd2;
  localparam logic [2:0] W_HOLD   = 3'd3;
  localparam logic [2:0] R_ACCESS = 3'd4;
  localparam logic [2:0] R_TURN   = 3'd5;

  // The down-counter is loaded with (cycles - 1) on entry; a state ends when it hits zero.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] READ_LD  = 4'(READ_CYC - 1);

  logic [2:0]        state;
  logic [3:0]        cnt;
  logic              dbus_oe;
  logic [DATA_W-1:0] dbus_out;

  assign req_ready = (state == IDLE);
  assign sram_dbus = dbus_oe ? dbus_out : 'z;

  // Transaction sequencer: state, timing counter and all registered SRAM pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sram_csb  <= 1'b1;
      sram_wrb  <= 1'b1;
      sram_abus <= '0;
      dbus_oe   <= 1'b0;
      dbus_out  <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            sram_abus <= req_addr;
            sram_csb  <= 1'b0;
            sram_wrb  <= 1'b1;
            if (req_we) begin
              dbus_out <= req_wdata;
              dbus_oe  <= 1'b1;
              cnt      <= SETUP_LD;
              state    <= W_SETUP;
            end else begin
              dbus_oe  <= 1'b0;
              cnt      <= READ_LD;
              state    <= R_ACCESS;
            end
          end
        end
        W_SETUP: begin
          if (cnt == 4'd0) begin
            sram_wrb <= 1'b0;
            cnt      <= PULSE_LD;
            state    <= W_PULSE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        W_PULSE: begin
          if (cnt == 4'd0) begin
            sram_wrb <= 1'b1;
            cnt      <= '0;
            state    <= W_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        W_HOLD: begin
          sram_csb <= 1'b1;
          dbus_oe  <= 1'b0;
          state    <= IDLE;
        end
        R_ACCESS: begin
          if (cnt == 4'd0) begin
            rd_data  <= sram_dbus;
            rd_valid <= 1'b1;
            sram_csb <= 1'b1;
            state    <= R_TURN;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        R_TURN: begin
          state <= IDLE;
        end
        default: begin
          sram_csb <= 1'b1;
          sram_wrb <= 1'b1;
          dbus_oe  <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: bench for sram_ctrl with an async SRAM model and a
// phase-count reference model checked every cycle.
`timescale 1ns/1ps

module tb_sram_ctrl;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int S  = 1;
  localparam int P  = 2;
  localparam int R  = 2;
  localparam int WL = S + P + 1;
  localparam int RL = R + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b1;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          sram_csb, sram_wrb;
  logic [AW-1:0] sram_abus;
  wire  [DW-1:0] sram_dbus;

  logic          req_valid2, req_ready2, req_we2;
  logic [AW-1:0] req_addr2;
  logic [DW-1:0] req_wdata2;
  logic          rd_valid2;
  logic [DW-1:0] rd_data2;
  logic          csb2, wrb2;
  logic [AW-1:0] abus2;
  wire  [DW-1:0] dbus2;
  logic          rd2_mode = 1'b0;

  int total = 0;
  int bad   = 0;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(S), .PULSE_CYC(P), .READ_CYC(R)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .sram_csb(sram_csb), .sram_wrb(sram_wrb),
    .sram_abus(sram_abus), .sram_dbus(sram_dbus)
  );

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(3), .PULSE_CYC(1), .READ_CYC(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rd_valid(rd_valid2), .rd_data(rd_data2), .sram_csb(csb2), .sram_wrb(wrb2),
    .sram_abus(abus2), .sram_dbus(dbus2)
  );

  // Second SRAM is a constant-data responder; only timing matters there.
  assign dbus2 = (!csb2 && wrb2 && rd2_mode) ? 8'h96 : 'z;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // SRAM model: drives data during read access, captures on wrb rising edge.
  logic [DW-1:0] sram_mem [0:4095];
  logic [DW-1:0] ref_mem  [0:4095];
  logic          sram_oe_q = 1'b0;
  logic [DW-1:0] sram_q;
  realtime       t_abus = 0.0;

  assign sram_q    = sram_mem[sram_abus];
  assign sram_dbus = (!sram_csb && sram_wrb && sram_oe_q) ? sram_q : 'z;

  always @(sram_abus) t_abus = $realtime;

  always @(posedge sram_wrb) begin
    if (reset_n && !sram_csb) begin
      sram_mem[sram_abus] = sram_dbus;
      chk("wr_setup_10ns", ($realtime - t_abus) >= 10.0, 1);
    end
  end

  // Reference model: t counts cycles since acceptance (0 = idle).
  int            t = 0;
  int            m_len = 0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [AW-1:0] exp_abus = '0;
  logic [DW-1:0] exp_rd = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t = 0; m_len = 0; exp_abus = '0; exp_rd = '0;
    end else if (t == 0) begin
      if (req_valid) begin
        t = 1; m_we = req_we; m_addr = req_addr; m_data = req_wdata;
        exp_abus = req_addr;
        m_len = req_we ? WL : RL;
      end
    end else begin
      if (!m_we && t == R) exp_rd = ref_mem[m_addr];
      if (t == m_len) begin
        if (m_we) ref_mem[m_addr] = m_data;
        t = 0;
      end else begin
        t++;
      end
    end
  end

  // Per-cycle comparison of DUT pins against the model.
  always @(negedge clk) begin
    sram_oe_q = reset_n && !m_we && t >= 1 && t <= R;
    if (reset_n) begin
      chk("req_ready", req_ready, t == 0);
      chk("csb", sram_csb, !(t >= 1 && t <= (m_we ? WL : R)));
      chk("wrb", sram_wrb, !(t >= 1 && m_we && t > S && t <= S + P));
      chk("rd_valid", rd_valid, t >= 1 && !m_we && t == RL);
      chk("abus", sram_abus, exp_abus);
      chk("rd_data", rd_data, exp_rd);
      if (t >= 1 && m_we) chk("dbus_wdata", sram_dbus, m_data);
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", req_ready, 1);
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  task automatic wait_rd(input string name, input logic [DW-1:0] exp);
    int n = 0;
    while (!rd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, rd_valid, 1);
    chk(name, rd_data, exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] csb_v, wrb_v, rdy_v;
    logic [3:0] rv_v, rr_v;
    logic [DW-1:0] d_c3;
    int n, csb_low, wrb_low;
    bit found;

    for (int i = 0; i < 4096; i++) begin
      sram_mem[i] = 8'(i * 7 + 3);
      ref_mem[i]  = sram_mem[i];
    end
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    req_valid2 = 0; req_we2 = 0; req_addr2 = '0; req_wdata2 = '0;

    // Asynchronous reset, checked before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_csb", sram_csb, 1);
    chk("rst_wrb", sram_wrb, 1);
    chk("rst_abus", sram_abus, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);

    // Single write 0x123 = 0xA5.
    send(1'b1, 12'h123, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 1'b0;
      csb_v[i] = sram_csb; wrb_v[i] = sram_wrb; rdy_v[i] = req_ready;
    end
    chk("w1_csb_pattern", csb_v, 5'b10000);
    chk("w1_wrb_pattern", wrb_v, 5'b11001);
    chk("w1_ready_pattern", rdy_v, 5'b10000);
    chk("w1_cell_123", sram_mem[12'h123], 8'hA5);

    // Single read of 0x123.
    send(1'b0, 12'h123, 8'h00);
    d_c3 = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 1'b0;
      rv_v[i] = rd_valid; rr_v[i] = req_ready;
      if (i == 2) d_c3 = rd_data;
    end
    chk("r1_valid_pattern", rv_v, 4'b0100);
    chk("r1_ready_pattern", rr_v, 4'b1000);
    chk("r1_data", d_c3, 8'hA5);

    // Read then write to the same address held valid, then read back.
    send(1'b0, 12'h010, 8'h00);
    send(1'b1, 12'h010, 8'h3C);
    send(1'b0, 12'h010, 8'h00);
    drop();
    wait_rd("rw_readback", 8'h3C);

    // Streaming writes then reads.
    for (int a = 0; a < 16; a++) send(1'b1, AW'(a), DW'(a) ^ 8'h5A);
    for (int a = 0; a < 16; a++) send(1'b0, AW'(a), 8'h00);
    drop();
    wait_rd("stream_last", 8'h55);

    // Randomized traffic with idle gaps carrying garbage request fields.
    for (int k = 0; k < 300; k++) begin
      send(1'($urandom), AW'($urandom_range(0, 31)), DW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        drop();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drop();
    repeat (8) @(negedge clk);

    // Reset during the write pulse.
    send(1'b1, 12'h200, 8'h77);
    drop();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!sram_wrb) found = 1'b1;
      else @(negedge clk);
    end
    chk("midrst_in_pulse", found, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_csb", sram_csb, 1);
    chk("midrst_wrb", sram_wrb, 1);
    chk("midrst_abus", sram_abus, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", req_ready, 1);
    send(1'b1, 12'h201, 8'h5E);
    send(1'b0, 12'h201, 8'h00);
    drop();
    wait_rd("midrst_readback", 8'h5E);

    // Parameter sweep instance: SETUP=3, PULSE=1, READ=4.
    @(negedge clk);
    chk("p2_ready_idle", req_ready2, 1);
    req_valid2 = 1'b1; req_we2 = 1'b1; req_addr2 = 12'h0AB; req_wdata2 = 8'h11;
    @(posedge clk);
    @(negedge clk);
    req_valid2 = 1'b0;
    n = 0; csb_low = 0; wrb_low = 0;
    while (!req_ready2 && n < 40) begin
      n++;
      if (!csb2) csb_low++;
      if (!wrb2) wrb_low++;
      @(negedge clk);
    end
    chk("p2_write_cycles", n, 5);
    chk("p2_csb_low", csb_low, 5);
    chk("p2_wrb_low", wrb_low, 1);
    rd2_mode = 1'b1;
    req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = 12'h0AB;
    @(posedge clk);
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      @(negedge clk);
      req_valid2 = 1'b0;
      n++;
      if (rd_valid2) found = 1'b1;
    end
    chk("p2_read_latency", n, 5);
    chk("p2_rd_data", rd_data2, 8'h96);
    rd2_mode = 1'b0;

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
